// File: rtl/phys_reg_free_list_if.sv
// Rename/retire-side bus of the physical register free list.
// The master modport belongs to the pipeline and the slave modport to the free list.
interface phys_reg_free_list_if #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int LOG_PHYS      = $clog2(NUM_PHYS_REGS)
);
  logic                alloc_req;
  logic                alloc_valid;
  logic [LOG_PHYS-1:0] alloc_preg;
  logic                free_valid;
  logic [LOG_PHYS-1:0] free_preg;
  logic                commit_alloc;
  logic                flush;
  logic [LOG_PHYS:0]   free_count;
  logic                err;

  modport master (
    output alloc_req,
    output free_valid,
    output free_preg,
    output commit_alloc,
    output flush,
    input  alloc_valid,
    input  alloc_preg,
    input  free_count,
    input  err
  );

  modport slave (
    input  alloc_req,
    input  free_valid,
    input  free_preg,
    input  commit_alloc,
    input  flush,
    output alloc_valid,
    output alloc_preg,
    output free_count,
    output err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with separate speculative and committed heads.
// A flush rewinds the speculative head to the committed one in a single cycle.
module phys_reg_free_list #(
  parameter int NUM_ARCH_REGS = 35,
  parameter int NUM_PHYS_REGS = 64,
  parameter int LOG_PHYS      = $clog2(NUM_PHYS_REGS)
) (
  input logic                   CLK,
  input logic                   RESET,
  phys_reg_free_list_if.slave   bus
);

  localparam logic [LOG_PHYS:0]   FULL_CNT = (LOG_PHYS+1)'(NUM_PHYS_REGS - 1);
  localparam logic [LOG_PHYS-1:0] PTR_ONE  = LOG_PHYS'(1);
  localparam logic [LOG_PHYS-1:0] PTR_ZERO = '0;

  if ((NUM_PHYS_REGS & (NUM_PHYS_REGS - 1)) != 0) begin : g_bad_depth
    $error("phys_reg_free_list: NUM_PHYS_REGS must be a power of two");
  end
  if (NUM_ARCH_REGS >= NUM_PHYS_REGS) begin : g_bad_arch
    $error("phys_reg_free_list: NUM_ARCH_REGS must be below NUM_PHYS_REGS");
  end

  logic [LOG_PHYS-1:0] mem [NUM_PHYS_REGS];

  logic [LOG_PHYS-1:0] spec_head_reg,   spec_head_next;
  logic [LOG_PHYS-1:0] commit_head_reg, commit_head_next;
  logic [LOG_PHYS-1:0] tail_reg,        tail_next;
  logic [LOG_PHYS:0]   spec_cnt_reg,    spec_cnt_next;
  logic [LOG_PHYS:0]   commit_cnt_reg,  commit_cnt_next;
  logic                err_reg,         err_next;

  logic grant;
  logic free_hit;
  logic free_ok;
  logic free_err;
  logic commit_ok;
  logic commit_err;

  logic [LOG_PHYS:0] free_inc;
  logic [LOG_PHYS:0] commit_dec;
  logic [LOG_PHYS:0] grant_dec;

  logic [NUM_PHYS_REGS-1:0] slot_we;

  // Allocation is blocked during a flush so rename never sees a tag about to be rewound.
  assign bus.alloc_valid = (spec_cnt_reg != '0) && !bus.flush;
  assign bus.alloc_preg  = mem[spec_head_reg];
  assign bus.free_count  = spec_cnt_reg;
  assign bus.err         = err_reg;

  assign grant      = bus.alloc_req && bus.alloc_valid;
  assign free_hit   = bus.free_valid && (bus.free_preg != PTR_ZERO);
  assign free_ok    = free_hit && (commit_cnt_reg != FULL_CNT);
  assign free_err   = free_hit && (commit_cnt_reg == FULL_CNT);
  assign commit_ok  = bus.commit_alloc && (commit_head_reg != spec_head_reg);
  assign commit_err = bus.commit_alloc && (commit_head_reg == spec_head_reg);

  assign free_inc   = {PTR_ZERO, free_ok};
  assign commit_dec = {PTR_ZERO, commit_ok};
  assign grant_dec  = {PTR_ZERO, grant};

  for (genvar gi = 0; gi < NUM_PHYS_REGS; gi++) begin : g_slot_we
    assign slot_we[gi] = free_ok && (tail_reg == LOG_PHYS'(gi));
  end

  always_comb begin
    tail_next        = tail_reg;
    commit_head_next = commit_head_reg;
    commit_cnt_next  = commit_cnt_reg;
    spec_head_next   = spec_head_reg;
    spec_cnt_next    = spec_cnt_reg;
    err_next         = err_reg | free_err | commit_err;

    if (free_ok) begin
      tail_next = tail_reg + PTR_ONE;
    end
    if (commit_ok) begin
      commit_head_next = commit_head_reg + PTR_ONE;
    end
    commit_cnt_next = commit_cnt_reg + free_inc - commit_dec;

    // On flush the speculative view collapses onto the post-update committed view.
    if (bus.flush) begin
      spec_head_next = commit_head_next;
      spec_cnt_next  = commit_cnt_next;
    end else begin
      if (grant) begin
        spec_head_next = spec_head_reg + PTR_ONE;
      end
      spec_cnt_next = spec_cnt_reg + free_inc - grant_dec;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      spec_head_reg   <= '0;
      commit_head_reg <= '0;
      tail_reg        <= LOG_PHYS'(NUM_PHYS_REGS - 1);
      spec_cnt_reg    <= FULL_CNT;
      commit_cnt_reg  <= FULL_CNT;
      err_reg         <= 1'b0;
    end else begin
      spec_head_reg   <= spec_head_next;
      commit_head_reg <= commit_head_next;
      tail_reg        <= tail_next;
      spec_cnt_reg    <= spec_cnt_next;
      commit_cnt_reg  <= commit_cnt_next;
      err_reg         <= err_next;
    end
  end

  // Reset image holds tags 1..N-1 in order; the last slot is the unused gap and holds tag 0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        mem[i] <= LOG_PHYS'((i + 1) % NUM_PHYS_REGS);
      end
    end else begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        if (slot_we[i]) begin
          mem[i] <= bus.free_preg;
        end
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: stimulus queues expectations, a negedge monitor checks them.
module tb_phys_reg_free_list;

  typedef struct {
    logic       valid;
    logic [5:0] tag;
  } alloc_rec_t;

  typedef struct {
    string      name;
    logic       av;
    logic       chk_preg;
    logic [5:0] preg;
    logic [6:0] cnt;
    logic       err;
  } stat_rec_t;

  logic CLK;
  logic RESET;

  int tests_run;
  int tests_failed;
  int alloc_idx;

  alloc_rec_t alloc_q[$];
  stat_rec_t  stat_q[$];

  phys_reg_free_list_if #(.NUM_PHYS_REGS(64)) bus ();

  phys_reg_free_list #(
    .NUM_ARCH_REGS(35),
    .NUM_PHYS_REGS(64)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic drive(input logic req, input logic fv, input logic [5:0] fp,
                       input logic ca, input logic fl);
    bus.alloc_req    = req;
    bus.free_valid   = fv;
    bus.free_preg    = fp;
    bus.commit_alloc = ca;
    bus.flush        = fl;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_alloc(input logic v, input logic [5:0] t);
    alloc_rec_t r;
    r.valid = v;
    r.tag   = t;
    alloc_q.push_back(r);
  endtask

  task automatic exp_stat(input string n, input logic av, input logic cp,
                          input logic [5:0] p, input logic [6:0] c, input logic e);
    stat_rec_t r;
    r.name     = n;
    r.av       = av;
    r.chk_preg = cp;
    r.preg     = p;
    r.cnt      = c;
    r.err      = e;
    stat_q.push_back(r);
  endtask

  task automatic do_reset();
    drive(0, 0, 6'd0, 0, 0);
    RESET = 1'b0;
    step();
    step();
    RESET = 1'b1;
    exp_stat("reset", 1'b1, 1'b1, 6'd1, 7'd63, 1'b0);
    step();
  endtask

  function automatic logic [5:0] stream_tag(input int i);
    return 6'((i % 63) + 1);
  endfunction

  // Monitor: every alloc_req cycle consumes one alloc record; status records drain each negedge.
  always begin
    alloc_rec_t a;
    stat_rec_t  s;
    @(negedge CLK);
    if (bus.alloc_req) begin
      tests_run++;
      if (alloc_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL alloc_unexpected #%0d: got valid=%0b tag=%0d, required no request",
                 alloc_idx, bus.alloc_valid, bus.alloc_preg);
      end else begin
        a = alloc_q.pop_front();
        if (bus.alloc_valid !== a.valid || (a.valid && bus.alloc_preg !== a.tag)) begin
          tests_failed++;
          $display("[TB] FAIL alloc #%0d: got valid=%0b tag=%0d, required valid=%0b tag=%0d",
                   alloc_idx, bus.alloc_valid, bus.alloc_preg, a.valid, a.tag);
        end else begin
          $display("[TB] alloc #%0d valid=%0b tag=%0d ok", alloc_idx, a.valid, a.tag);
        end
      end
      alloc_idx++;
    end
    while (stat_q.size() != 0) begin
      s = stat_q.pop_front();
      tests_run++;
      if (bus.alloc_valid !== s.av || bus.free_count !== s.cnt || bus.err !== s.err ||
          (s.chk_preg && bus.alloc_preg !== s.preg)) begin
        tests_failed++;
        $display("[TB] FAIL %s: got valid=%0b preg=%0d count=%0d err=%0b, required valid=%0b preg=%0d count=%0d err=%0b",
                 s.name, bus.alloc_valid, bus.alloc_preg, bus.free_count, bus.err,
                 s.av, s.preg, s.cnt, s.err);
      end else begin
        $display("[TB] status %s valid=%0b count=%0d err=%0b ok", s.name, s.av, s.cnt, s.err);
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    alloc_idx    = 0;
    RESET        = 1'b0;
    drive(0, 0, 6'd0, 0, 0);

    // Drain the whole list in order.
    do_reset();
    for (int k = 1; k <= 63; k++) begin
      drive(1, 0, 6'd0, 0, 0);
      exp_alloc(1'b1, 6'(k));
      step();
    end
    drive(1, 0, 6'd0, 0, 0);
    exp_alloc(1'b0, 6'd0);
    exp_stat("empty", 1'b0, 1'b0, 6'd0, 7'd0, 1'b0);
    step();

    // Retire everything so returned tags have room.
    for (int k = 0; k < 63; k++) begin
      drive(0, 0, 6'd0, 1, 0);
      step();
    end

    // Free into an empty list: no same-cycle bypass.
    drive(1, 1, 6'd5, 0, 0);
    exp_alloc(1'b0, 6'd0);
    step();
    drive(0, 0, 6'd0, 0, 0);
    exp_stat("free_into_empty", 1'b1, 1'b1, 6'd5, 7'd1, 1'b0);
    step();
    // Grant and free together at spec_cnt==1.
    drive(1, 1, 6'd9, 0, 0);
    exp_alloc(1'b1, 6'd5);
    step();
    drive(0, 0, 6'd0, 0, 0);
    exp_stat("grant_free_cnt1", 1'b1, 1'b1, 6'd9, 7'd1, 1'b0);
    step();
    drive(1, 0, 6'd0, 0, 0);
    exp_alloc(1'b1, 6'd9);
    step();
    drive(0, 0, 6'd0, 0, 0);
    exp_stat("empty_again", 1'b0, 1'b0, 6'd0, 7'd0, 1'b0);
    step();

    // Flush rewinds to the committed head.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 0, 6'd0, 0, 0);
      exp_alloc(1'b1, 6'(k));
      step();
    end
    drive(0, 0, 6'd0, 1, 0);
    step();
    step();
    drive(1, 0, 6'd0, 0, 1);
    exp_alloc(1'b0, 6'd0);
    step();
    drive(0, 0, 6'd0, 0, 0);
    exp_stat("after_flush", 1'b1, 1'b1, 6'd3, 7'd61, 1'b0);
    step();
    for (int k = 3; k <= 5; k++) begin
      drive(1, 0, 6'd0, 0, 0);
      exp_alloc(1'b1, 6'(k));
      step();
    end
    // Flush with a same-cycle commit lands one past the old committed head.
    drive(0, 0, 6'd0, 1, 1);
    step();
    drive(0, 0, 6'd0, 0, 0);
    exp_stat("flush_commit", 1'b1, 1'b1, 6'd4, 7'd60, 1'b0);
    step();

    // Tag 0 is silently dropped.
    drive(0, 1, 6'd0, 0, 0);
    step();
    drive(0, 0, 6'd0, 0, 0);
    exp_stat("free_zero", 1'b1, 1'b1, 6'd4, 7'd60, 1'b0);
    step();

    // Free into a full list raises err.
    do_reset();
    drive(0, 1, 6'd7, 0, 0);
    step();
    drive(0, 0, 6'd0, 0, 0);
    exp_stat("free_full_err", 1'b1, 1'b1, 6'd1, 7'd63, 1'b1);
    step();
    exp_stat("err_sticky", 1'b1, 1'b1, 6'd1, 7'd63, 1'b1);
    step();

    // Commit with nothing outstanding raises err.
    do_reset();
    drive(0, 0, 6'd0, 1, 0);
    step();
    drive(0, 0, 6'd0, 0, 0);
    exp_stat("commit_empty_err", 1'b1, 1'b1, 6'd1, 7'd63, 1'b1);
    step();

    // Steady stream: grant, commit and free the tag granted two cycles earlier.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive(1, (i >= 2), (i >= 2) ? stream_tag(i - 2) : 6'd0, (i >= 1), 0);
      exp_alloc(1'b1, stream_tag(i));
      if (i == 100) begin
        exp_stat("stream", 1'b1, 1'b1, stream_tag(i), 7'd61, 1'b0);
      end
      step();
    end

    // Reset asserted between clock edges must take effect before the next edge.
    drive(0, 1, stream_tag(198), 1, 0);
    #2;
    RESET = 1'b0;
    exp_stat("async_reset", 1'b1, 1'b1, 6'd1, 7'd63, 1'b0);
    step();
    RESET = 1'b1;
    drive(0, 0, 6'd0, 0, 0);
    exp_stat("post_reset", 1'b1, 1'b1, 6'd1, 7'd63, 1'b0);
    step();
    step();

    tests_run++;
    if (alloc_q.size() != 0 || stat_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL queue_drain: got %0d alloc and %0d status records left, required 0 and 0",
               alloc_q.size(), stat_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
